// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - four-channel key debouncer with press/release edges and auto-repeat
module key_debounce #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  output logic [3:0] KEY_LEVEL,
  output logic [3:0] KEY_PRESS,
  output logic [3:0] KEY_RELEASE,
  output logic [3:0] KEY_REPEAT
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DBW     = $clog2(DB_CYCLES);
  localparam int RPW     = $clog2(RPT_MAX);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_INC   = DBW'(1);
  localparam logic [RPW-1:0] RD_LAST  = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RP_LAST  = RPW'(REPEAT_PERIOD - 1);
  localparam logic [RPW-1:0] RPT_INC  = RPW'(1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_e;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    logic           sync1_q, sync1_d, sync2_q, sync2_d;
    logic           level_q, level_d;
    logic           press_q, press_d, release_q, release_d, repeat_q, repeat_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [RPW-1:0] rpt_cnt_q, rpt_cnt_d;
    rpt_state_e     state_q, state_d;
    logic           s;

    // Inversion happens ahead of the synchronizer so reset leaves it reading "released".
    assign sync1_d = ~KEY[i];
    assign sync2_d = sync1_q;
    assign s       = sync2_q;

    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (s != level_q) begin
        if (db_cnt_q == DB_LAST) level_d = s;
        else                     db_cnt_d = db_cnt_q + DB_INC;
      end
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      case (state_q)
        IDLE: begin
          rpt_cnt_d = '0;
          if (press_d) state_d = HOLD;
        end
        HOLD: begin
          if (!level_d) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RD_LAST) begin
            state_d   = RPT;
            rpt_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_INC;
          end
        end
        RPT: begin
          if (!level_d) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RP_LAST) begin
            rpt_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_INC;
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        state_q   <= IDLE;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
        db_cnt_q  <= db_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        state_q   <= state_d;
      end
    end

    assign KEY_LEVEL[i]   = level_q;
    assign KEY_PRESS[i]   = press_q;
    assign KEY_RELEASE[i] = release_q;
    assign KEY_REPEAT[i]  = repeat_q;
  end

endmodule
